// File: rtl/biu_pkg.sv
// Shared definitions for the bus-interface transfer sequencer:
// FSM state encoding, beat-counter width and the default watchdog limit.
package biu_pkg;

  // A transaction moves at most 4 beats; 3 bits hold 0..4.
  localparam int BEAT_W          = 3;
  localparam int TIMEOUT_CYC_DEF = 15;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_XFER = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/biu_xfer_seq_if.sv
// Memory-side bus of the transfer sequencer. The sequencer is the master;
// the memory (or its model) is the slave.
interface biu_xfer_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/biu_addr_cnt.sv
// Word-address counter: load has priority over increment; increments wrap
// modulo 2^ADDR_W.
module biu_addr_cnt #(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] cnt
);

  // Load a new start address or step to the next word on each accepted beat.
  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)     cnt <= '0;
    else if (load) cnt <= load_val;
    else if (inc)  cnt <= cnt + ADDR_W'(1);
  end

endmodule

// File: rtl/biu_xfer_seq.sv
// Bus-interface transfer sequencer: turns one request from the execution unit
// into a single write beat or a 1..4 beat read burst on the memory bus.
// Optional build macro BIU_TIMEOUT_EN adds a per-beat watchdog that aborts
// the transaction with err after TIMEOUT_CYC consecutive wait cycles.
module biu_xfer_seq
  import biu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        len,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              done,
  output logic              err,
  biu_xfer_seq_if.master    mem
);

  state_t            state;
  state_t            state_nxt;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BEAT_W-1:0] beats_q;
  logic [ADDR_W-1:0] addr_cnt;
  logic              start;
  logic              beat_ok;
  logic              last_beat;
  logic              timeout;

  // A request is only taken in IDLE; anything arriving later is dropped.
  assign start     = (state == ST_IDLE) && req;
  assign beat_ok   = (state == ST_XFER) && mem.mem_ready;
  assign last_beat = beat_ok && (beats_q == BEAT_W'(1));

  biu_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (start),
    .inc      (beat_ok),
    .load_val (addr),
    .cnt      (addr_cnt)
  );

`ifdef BIU_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_q;
  logic              err_q;

  // The wait cycle that would bring the counter to TIMEOUT_CYC aborts,
  // unless the memory answers in that same cycle.
  assign timeout = (state == ST_XFER) && !mem.mem_ready &&
                   (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

  // Count consecutive stalled cycles of the current beat.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                   wait_q <= '0;
    else if (start || beat_ok)   wait_q <= '0;
    else if (state == ST_XFER)   wait_q <= wait_q + WAIT_W'(1);
  end

  // Remember why XFER ended so err can accompany done.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)        err_q <= 1'b0;
    else if (start)   err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign err = (state == ST_DONE) && err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state decode for the IDLE -> XFER -> DONE -> IDLE sequence.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req)                  state_nxt = ST_XFER;
      ST_XFER: if (last_beat || timeout) state_nxt = ST_DONE;
      ST_DONE:                           state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Capture the transaction and count down the remaining beats.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      we_q    <= 1'b0;
      wdata_q <= '0;
      beats_q <= '0;
    end else if (start) begin
      we_q    <= we;
      wdata_q <= wdata;
      beats_q <= we ? BEAT_W'(1) : ({1'b0, len} + BEAT_W'(1));
    end else if (beat_ok) begin
      beats_q <= beats_q - BEAT_W'(1);
    end
  end

  // Register each read beat and flag it for one cycle; rdata holds otherwise.
  // NOTE: rdata is reset as well, since its value after reset is visible.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= beat_ok && !we_q;
      if (beat_ok && !we_q) rdata <= mem.mem_rdata;
    end
  end

  assign busy          = (state == ST_XFER);
  assign done          = (state == ST_DONE);
  assign mem.mem_rd    = busy && !we_q;
  assign mem.mem_wr    = busy && we_q;
  assign mem.mem_addr  = addr_cnt;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_biu_xfer_seq.sv
// Directed bench for biu_xfer_seq: a table of transactions with hand-computed
// results, plus hand-written sequences for request-ignore, watchdog/stall and
// mid-transaction reset. Build with +define+BIU_TIMEOUT_EN for the watchdog.
module tb_biu_xfer_seq;

  logic        Clk;
  logic        Reset;
  logic        req;
  logic        we;
  logic [1:0]  len;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] rdata;
  logic        rvalid;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  biu_xfer_seq_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  biu_xfer_seq #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(15)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .req    (req),
    .we     (we),
    .len    (len),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .rdata  (rdata),
    .rvalid (rvalid),
    .done   (done),
    .err    (err),
    .mem    (mem_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench did not terminate");
  end

  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rbase;          // memory returns rbase + beat index
    int          wait_cyc;       // stall cycles before each beat
    int          exp_beats;
    int          exp_rvalids;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_last_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one transaction and act as the memory until done (bounded).
  task automatic run_vec(input int idx, input vec_t v);
    int          beats = 0;
    int          rv = 0;
    int          wait_left = v.wait_cyc;
    bit          done_seen = 0;
    logic [31:0] last_a = 32'h0;
    req = 1'b1; we = v.we; len = v.len; addr = v.addr; wdata = v.wdata;
    @(negedge Clk);
    req = 1'b0; we = ~v.we; len = ~v.len; addr = ~v.addr; wdata = ~v.wdata;
    check($sformatf("v%0d_busy_first", idx), {31'b0, busy}, 32'd1);
    check($sformatf("v%0d_strobe_first", idx), {31'b0, mem_if.mem_rd | mem_if.mem_wr}, 32'd1);
    for (int cyc = 0; cyc < 64 && !done_seen; cyc++) begin
      if (rvalid) begin
        rv++;
        check($sformatf("v%0d_rdata_beat%0d", idx, rv - 1), rdata, v.rbase + 32'(rv - 1));
      end else if (rv > 0) begin
        check($sformatf("v%0d_rdata_hold", idx), rdata, v.rbase + 32'(rv - 1));
      end
      if (done) begin
        done_seen = 1;
        check($sformatf("v%0d_err", idx), {31'b0, err}, 32'd0);
        check($sformatf("v%0d_strobe_off", idx), {31'b0, mem_if.mem_rd | mem_if.mem_wr}, 32'd0);
        mem_if.mem_ready = 1'b0;
      end else if (mem_if.mem_rd || mem_if.mem_wr) begin
        check($sformatf("v%0d_rd_pol", idx), {31'b0, mem_if.mem_rd}, {31'b0, ~v.we});
        if (wait_left == 0) begin
          mem_if.mem_ready = 1'b1;
          mem_if.mem_rdata = v.rbase + 32'(beats);
          check($sformatf("v%0d_addr_beat%0d", idx, beats), mem_if.mem_addr, v.addr + 32'(beats));
          if (v.we) check($sformatf("v%0d_wdata", idx), mem_if.mem_wdata, v.wdata);
          last_a = mem_if.mem_addr;
          beats++;
          wait_left = v.wait_cyc;
        end else begin
          mem_if.mem_ready = 1'b0;
          mem_if.mem_rdata = 32'hA5A5A5A5;
          wait_left--;
        end
      end else begin
        mem_if.mem_ready = 1'b0;
      end
      if (!done_seen) @(negedge Clk);
    end
    check($sformatf("v%0d_done_seen", idx), {31'b0, done_seen}, 32'd1);
    check($sformatf("v%0d_beats", idx), 32'(beats), 32'(v.exp_beats));
    check($sformatf("v%0d_rvalids", idx), 32'(rv), 32'(v.exp_rvalids));
    check($sformatf("v%0d_last_addr", idx), last_a, v.exp_last_addr);
    check($sformatf("v%0d_last_rdata", idx), rdata, v.exp_last_rdata);
    @(negedge Clk);
    check($sformatf("v%0d_idle_busy", idx), {31'b0, busy}, 32'd0);
    check($sformatf("v%0d_done_once", idx), {31'b0, done}, 32'd0);
    check($sformatf("v%0d_rvalid_off", idx), {31'b0, rvalid}, 32'd0);
  endtask

  initial begin
    int  cnt;
    bit  saw_done;
    bit  saw_err;
    int  dn;

    //           we    len   addr          wdata         rbase         wait beats rv  last_addr     last_rdata
    vecs[0] = '{1'b0, 2'd0, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 0,   1,    1,  32'h00000100, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 2'd3, 32'hFFFFFFFE, 32'h00000000, 32'h000000A0, 1,   4,    4,  32'h00000001, 32'h000000A3};
    vecs[2] = '{1'b1, 2'd2, 32'h00000020, 32'h12345678, 32'h00000000, 0,   1,    0,  32'h00000020, 32'h000000A3};
    vecs[3] = '{1'b0, 2'd1, 32'h00000040, 32'h00000000, 32'h55AA0000, 2,   2,    2,  32'h00000041, 32'h55AA0001};
    vecs[4] = '{1'b1, 2'd0, 32'hFFFFFFFF, 32'hCAFEF00D, 32'h00000000, 3,   1,    0,  32'hFFFFFFFF, 32'h55AA0001};
    vecs[5] = '{1'b0, 2'd2, 32'h00000007, 32'h00000000, 32'h00000010, 0,   3,    3,  32'h00000009, 32'h00000012};

    Reset = 1'b1; req = 1'b0; we = 1'b0; len = 2'd0; addr = 32'h0; wdata = 32'h0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 32'h0;
    #1;
    check("rst_busy",   {31'b0, busy},           32'd0);
    check("rst_rvalid", {31'b0, rvalid},         32'd0);
    check("rst_done",   {31'b0, done},           32'd0);
    check("rst_err",    {31'b0, err},            32'd0);
    check("rst_rdata",  rdata,                   32'd0);
    check("rst_strobe", {31'b0, mem_if.mem_rd | mem_if.mem_wr}, 32'd0);
    check("rst_maddr",  mem_if.mem_addr,         32'd0);
    check("rst_mwdata", mem_if.mem_wdata,        32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Request held high through a stalled transaction must not queue another.
    req = 1'b1; we = 1'b0; len = 2'd0; addr = 32'h200; mem_if.mem_ready = 1'b0;
    @(negedge Clk);
    addr = 32'h2F0; len = 2'd3;
    check("ign_strobe", {31'b0, mem_if.mem_rd}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("ign_addr_hold", mem_if.mem_addr, 32'h200);
    end
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h77;
    @(negedge Clk);
    mem_if.mem_ready = 1'b0; req = 1'b0;
    check("ign_done",  {31'b0, done},   32'd1);
    check("ign_rdata", rdata,           32'h77);
    @(negedge Clk);
    check("ign_no_queue", {31'b0, busy | mem_if.mem_rd}, 32'd0);

    // Memory never answers: watchdog abort, or an indefinite wait without it.
    req = 1'b1; we = 1'b0; len = 2'd0; addr = 32'h300; mem_if.mem_ready = 1'b0;
    @(negedge Clk);
    req = 1'b0;
    cnt = 0; saw_done = 0; saw_err = 0;
    for (int i = 0; i < 100; i++) begin
      if (mem_if.mem_rd) cnt++;
      if (done) begin saw_done = 1; saw_err = err; break; end
      @(negedge Clk);
    end
`ifdef BIU_TIMEOUT_EN
    check("to_strobe_cycles", 32'(cnt), 32'd15);
    check("to_done", {31'b0, saw_done}, 32'd1);
    check("to_err",  {31'b0, saw_err},  32'd1);
    check("to_no_rvalid", {31'b0, rvalid}, 32'd0);
    @(negedge Clk);
    check("to_idle", {31'b0, busy | err}, 32'd0);
    // Ready arriving on the final allowed wait cycle completes the beat.
    req = 1'b1;
    @(negedge Clk);
    req = 1'b0;
    for (int i = 0; i < 14; i++) @(negedge Clk);
    check("tw_strobe_15", {31'b0, mem_if.mem_rd}, 32'd1);
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h5A5A0001;
    @(negedge Clk);
    mem_if.mem_ready = 1'b0;
    check("tw_done",   {31'b0, done},   32'd1);
    check("tw_err",    {31'b0, err},    32'd0);
    check("tw_rvalid", {31'b0, rvalid}, 32'd1);
    @(negedge Clk);
`else
    check("st_strobe_cycles", 32'(cnt), 32'd100);
    check("st_no_done", {31'b0, saw_done}, 32'd0);
    check("st_strobe_still", {31'b0, mem_if.mem_rd}, 32'd1);
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h5A5A0002;
    @(negedge Clk);
    mem_if.mem_ready = 1'b0;
    check("st_done", {31'b0, done}, 32'd1);
    check("st_err",  {31'b0, err},  32'd0);
    @(negedge Clk);
`endif

    // Reset during beat 2 of a 4-beat read aborts immediately, no done.
    req = 1'b1; we = 1'b0; len = 2'd3; addr = 32'h500;
    @(negedge Clk);
    req = 1'b0;
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h11;
    @(negedge Clk);
    mem_if.mem_ready = 1'b0;
    check("rm_beat2_addr", mem_if.mem_addr, 32'h501);
    check("rm_beat1_rvalid", {31'b0, rvalid}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("rm_strobe_off", {31'b0, mem_if.mem_rd | mem_if.mem_wr}, 32'd0);
    check("rm_busy",   {31'b0, busy},   32'd0);
    check("rm_rvalid", {31'b0, rvalid}, 32'd0);
    check("rm_done",   {31'b0, done},   32'd0);
    check("rm_rdata",  rdata,           32'd0);
    check("rm_maddr",  mem_if.mem_addr, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (done || busy) dn++;
    end
    check("rm_quiet_after", 32'(dn), 32'd0);
    run_vec(6, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
